alu_decode_stage: RTL and testbench

//  RV32I decode/issue stage: the producer side of the ALU interface. Registers one instruction per

---
 rtl/alu_pkg.sv | 61 ++++++
 rtl/alu_imm_gen.sv | 31 +++
 rtl/alu_decode_stage.sv | 223 ++++++++++++++++++++++
 tb/tb_alu_decode_stage.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU operation codes, RV32I opcode/funct fields and the immediate format selector.
// The alu_ctrl map is shared with the ALU in EX.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

  // alt selects SUB/SRA over ADD/SRL; it has no effect on the other funct3 values.
  function automatic logic [3:0] alu_op_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return alt ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_imm_gen.sv
// Combinational RV32I immediate extraction with sign extension for I/S/B/U/J formats.
module alu_imm_gen
  import alu_pkg::*;
(
  input  logic        [31:7] instr,
  input  imm_fmt_e           fmt,
  output logic signed [31:0] imm
);

  logic signed [11:0] imm_i;
  logic signed [11:0] imm_s;
  logic signed [12:0] imm_b;
  logic signed [20:0] imm_j;

  assign imm_i = instr[31:20];
  assign imm_s = {instr[31:25], instr[11:7]};
  assign imm_b = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    imm = 32'(imm_i);
    case (fmt)
      IMM_S:   imm = 32'(imm_s);
      IMM_B:   imm = 32'(imm_b);
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = 32'(imm_j);
      default: imm = 32'(imm_i);
    endcase
  end

endmodule

// File: rtl/alu_decode_stage.sv
// RV32I decode/issue stage feeding the ALU: one registered instruction slot with valid/ready.
// Define ALU_DECODE_PERF_EN to add the perf_issued / perf_stall counters.
module alu_decode_stage
  import alu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int PERF_CNT_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_operand_a,
  output logic [XLEN-1:0] out_operand_b,
  output logic [3:0]      out_alu_ctrl,
  output logic [4:0]      out_rd,
  output logic            out_reg_write,
  output logic            out_is_branch,
  output logic [2:0]      out_funct3,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal
`ifdef ALU_DECODE_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] perf_issued,
  output logic [PERF_CNT_W-1:0] perf_stall
`endif
);

  if (XLEN != 32) begin : g_xlen_check
    $error("alu_decode_stage supports XLEN=32 only");
  end
  if (PERF_CNT_W < 1) begin : g_perf_w_check
    $error("PERF_CNT_W must be at least 1");
  end

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign rd     = in_instr[11:7];

  imm_fmt_e           imm_fmt;
  logic signed [31:0] imm;

  alu_imm_gen u_imm_gen (
    .instr (in_instr[31:7]),
    .fmt   (imm_fmt),
    .imm   (imm)
  );

  logic [XLEN-1:0] dec_a;
  logic [XLEN-1:0] dec_b;
  logic [3:0]      dec_ctrl;
  logic            dec_rw;
  logic            dec_br;
  logic            dec_ill;

  always_comb begin
    imm_fmt  = IMM_I;
    dec_a    = '0;
    dec_b    = '0;
    dec_ctrl = ALU_ADD;
    dec_rw   = 1'b0;
    dec_br   = 1'b0;
    dec_ill  = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_a  = rs1_data;
        dec_b  = rs2_data;
        dec_rw = 1'b1;
        if (funct7 == F7_BASE)
          dec_ctrl = alu_op_f3(funct3, 1'b0);
        else if (funct7 == F7_ALT && (funct3 == F3_ADD || funct3 == F3_SR))
          dec_ctrl = alu_op_f3(funct3, 1'b1);
        else
          dec_ill = 1'b1;
      end
      OPC_OP_IMM: begin
        dec_a    = rs1_data;
        dec_b    = imm;
        dec_rw   = 1'b1;
        dec_ctrl = alu_op_f3(funct3, 1'b0);
        // Shifts take the 5-bit shamt; the upper immediate bits select SRL/SRA or are illegal.
        if (funct3 == F3_SLL) begin
          dec_b = {{(XLEN-5){1'b0}}, in_instr[24:20]};
          if (funct7 != F7_BASE) dec_ill = 1'b1;
        end else if (funct3 == F3_SR) begin
          dec_b = {{(XLEN-5){1'b0}}, in_instr[24:20]};
          if (funct7 == F7_ALT)       dec_ctrl = ALU_SRA;
          else if (funct7 != F7_BASE) dec_ill  = 1'b1;
        end
      end
      OPC_LUI: begin
        imm_fmt = IMM_U;
        dec_b   = imm;
        dec_rw  = 1'b1;
      end
      OPC_AUIPC: begin
        imm_fmt = IMM_U;
        dec_a   = in_pc;
        dec_b   = imm;
        dec_rw  = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        dec_a  = in_pc;
        dec_b  = XLEN'(4);
        dec_rw = 1'b1;
      end
      OPC_BRANCH: begin
        imm_fmt = IMM_B;
        dec_a   = rs1_data;
        dec_b   = rs2_data;
        dec_br  = 1'b1;
        case (funct3)
          F3_BEQ, F3_BNE:   dec_ctrl = ALU_SUB;
          F3_BLT, F3_BGE:   dec_ctrl = ALU_SLT;
          F3_BLTU, F3_BGEU: dec_ctrl = ALU_SLTU;
          default:          dec_ill  = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec_a  = rs1_data;
        dec_b  = imm;
        dec_rw = 1'b1;
      end
      OPC_STORE: begin
        imm_fmt = IMM_S;
        dec_a   = rs1_data;
        dec_b   = imm;
      end
      default: dec_ill = 1'b1;
    endcase
    if (dec_ill) begin
      dec_a    = '0;
      dec_b    = '0;
      dec_ctrl = ALU_ADD;
      dec_rw   = 1'b0;
      dec_br   = 1'b0;
    end
    if (rd == 5'd0) dec_rw = 1'b0;
  end

  logic accept;
  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // ---- stage boundary: decode -> issue register ----
  logic            vld_p1;
  logic [XLEN-1:0] opnd_a_p1;
  logic [XLEN-1:0] opnd_b_p1;
  logic [3:0]      ctrl_p1;
  logic [4:0]      rd_p1;
  logic            rw_p1;
  logic            br_p1;
  logic [2:0]      f3_p1;
  logic [XLEN-1:0] pc_p1;
  logic            ill_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      opnd_a_p1 <= '0;
      opnd_b_p1 <= '0;
      ctrl_p1   <= ALU_ADD;
      rd_p1     <= '0;
      rw_p1     <= 1'b0;
      br_p1     <= 1'b0;
      f3_p1     <= '0;
      pc_p1     <= '0;
      ill_p1    <= 1'b0;
    end else begin
      if (flush)          vld_p1 <= 1'b0;
      else if (accept)    vld_p1 <= 1'b1;
      else if (out_ready) vld_p1 <= 1'b0;
      if (accept) begin
        opnd_a_p1 <= dec_a;
        opnd_b_p1 <= dec_b;
        ctrl_p1   <= dec_ctrl;
        rd_p1     <= rd;
        rw_p1     <= dec_rw;
        br_p1     <= dec_br;
        f3_p1     <= funct3;
        pc_p1     <= in_pc;
        ill_p1    <= dec_ill;
      end
    end
  end

  assign out_valid     = vld_p1;
  assign out_operand_a = opnd_a_p1;
  assign out_operand_b = opnd_b_p1;
  assign out_alu_ctrl  = ctrl_p1;
  assign out_rd        = rd_p1;
  assign out_reg_write = rw_p1;
  assign out_is_branch = br_p1;
  assign out_funct3    = f3_p1;
  assign out_pc        = pc_p1;
  assign out_illegal   = ill_p1;

`ifdef ALU_DECODE_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else if (vld_p1) begin
      if (out_ready) perf_issued <= perf_issued + 1'b1;
      else           perf_stall  <= perf_stall + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed-vector bench for alu_decode_stage: decode table, handshake hold, flush, async reset.
module tb_alu_decode_stage;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_operand_a;
  logic [31:0] out_operand_b;
  logic [3:0]  out_alu_ctrl;
  logic [4:0]  out_rd;
  logic        out_reg_write;
  logic        out_is_branch;
  logic [2:0]  out_funct3;
  logic [31:0] out_pc;
  logic        out_illegal;
`ifdef ALU_DECODE_PERF_EN
  logic [31:0] perf_issued;
  logic [31:0] perf_stall;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_decode_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .in_pc         (in_pc),
    .rs1_data      (rs1_data),
    .rs2_data      (rs2_data),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_operand_a (out_operand_a),
    .out_operand_b (out_operand_b),
    .out_alu_ctrl  (out_alu_ctrl),
    .out_rd        (out_rd),
    .out_reg_write (out_reg_write),
    .out_is_branch (out_is_branch),
    .out_funct3    (out_funct3),
    .out_pc        (out_pc),
    .out_illegal   (out_illegal)
`ifdef ALU_DECODE_PERF_EN
    ,
    .perf_issued   (perf_issued),
    .perf_stall    (perf_stall)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one instruction for a single accepting edge; outputs are sampled 1ns later.
  task automatic send(input logic [31:0] instr, input logic [31:0] pc,
                      input logic [31:0] a, input logic [31:0] b);
    in_instr = instr;
    in_pc    = pc;
    rs1_data = a;
    rs2_data = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] ctrl, input logic [4:0] rd, input logic rw,
                            input logic br, input logic ill);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".a"}, out_operand_a, a);
    chk({tag, ".b"}, out_operand_b, b);
    chk({tag, ".ctrl"}, 32'(out_alu_ctrl), 32'(ctrl));
    chk({tag, ".rd"}, 32'(out_rd), 32'(rd));
    chk({tag, ".rw"}, 32'(out_reg_write), 32'(rw));
    chk({tag, ".br"}, 32'(out_is_branch), 32'(br));
    chk({tag, ".ill"}, 32'(out_illegal), 32'(ill));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    rs1_data  = '0;
    rs2_data  = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.ctrl", 32'(out_alu_ctrl), 32'(ALU_ADD));
    chk("rst.a", out_operand_a, 32'd0);
    chk("rst.pc", out_pc, 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    send(32'h002081B3, 32'h40, 32'd5, 32'd7);
    expect_out("add", 32'd5, 32'd7, ALU_ADD, 5'd3, 1'b1, 1'b0, 1'b0);
    chk("add.pc", out_pc, 32'h40);
    chk("add.f3", 32'(out_funct3), 32'd0);

    send(32'h402081B3, 32'h44, 32'd5, 32'd7);
    expect_out("sub", 32'd5, 32'd7, ALU_SUB, 5'd3, 1'b1, 1'b0, 1'b0);

    send(32'h40335293, 32'h48, 32'h80000000, 32'd0);
    expect_out("srai", 32'h80000000, 32'd3, 4'd9, 5'd5, 1'b1, 1'b0, 1'b0);

    send(32'h123450B7, 32'h4C, 32'hDEAD, 32'hBEEF);
    expect_out("lui", 32'd0, 32'h12345000, ALU_ADD, 5'd1, 1'b1, 1'b0, 1'b0);

    send(32'h00001117, 32'h100, 32'hDEAD, 32'hBEEF);
    expect_out("auipc", 32'h100, 32'h1000, ALU_ADD, 5'd2, 1'b1, 1'b0, 1'b0);

    send(32'hFFF00093, 32'h104, 32'd9, 32'd0);
    expect_out("addi_neg", 32'd9, 32'hFFFFFFFF, ALU_ADD, 5'd1, 1'b1, 1'b0, 1'b0);

    send(32'h00208063, 32'h108, 32'd11, 32'd12);
    expect_out("beq", 32'd11, 32'd12, ALU_SUB, 5'd0, 1'b0, 1'b1, 1'b0);

    send(32'h0020E063, 32'h10C, 32'd11, 32'd12);
    expect_out("bltu", 32'd11, 32'd12, ALU_SLTU, 5'd0, 1'b0, 1'b1, 1'b0);
    chk("bltu.f3", 32'(out_funct3), 32'd6);

    send(32'h00208033, 32'h110, 32'd1, 32'd2);
    expect_out("add_x0", 32'd1, 32'd2, ALU_ADD, 5'd0, 1'b0, 1'b0, 1'b0);

    send(32'h000000EF, 32'h200, 32'd1, 32'd2);
    expect_out("jal", 32'h200, 32'd4, ALU_ADD, 5'd1, 1'b1, 1'b0, 1'b0);

    send(32'hFE20AE23, 32'h204, 32'h1000, 32'd2);
    expect_out("sw_neg", 32'h1000, 32'hFFFFFFFC, ALU_ADD, 5'd28, 1'b0, 1'b0, 1'b0);

    send(32'hFFFFFFFF, 32'h208, 32'd3, 32'd4);
    expect_out("ill_ones", 32'd0, 32'd0, ALU_ADD, 5'd31, 1'b0, 1'b0, 1'b1);

    send(32'h40009093, 32'h20C, 32'd3, 32'd4);
    expect_out("ill_slli", 32'd0, 32'd0, ALU_ADD, 5'd1, 1'b0, 1'b0, 1'b1);

    @(posedge clk);
    #1;
    chk("idle.valid", 32'(out_valid), 32'd0);

    // Flush while holding a stalled instruction with a new one offered.
    out_ready = 1'b0;
    send(32'h002081B3, 32'h300, 32'd5, 32'd7);
    chk("fl.pre_valid", 32'(out_valid), 32'd1);
    in_instr = 32'h402081B3;
    in_valid = 1'b1;
    flush    = 1'b1;
    #1;
    chk("fl.in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl.valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("fl.dropped", 32'(out_valid), 32'd0);
    chk("fl.in_ready_after", 32'(in_ready), 32'd1);

    // Asynchronous reset discards a held instruction immediately.
    send(32'h002081B3, 32'h304, 32'd5, 32'd7);
    chk("ar.pre_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("ar.valid", 32'(out_valid), 32'd0);
    chk("ar.a", out_operand_a, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
`ifdef ALU_DECODE_PERF_EN
    chk("ar.perf_issued", perf_issued, 32'd0);
    chk("ar.perf_stall", perf_stall, 32'd0);
`endif

    // Back-pressure: held outputs frozen for 3 stalled edges, then two transfers.
    in_instr = 32'h002081B3;
    in_pc    = 32'h400;
    rs1_data = 32'd5;
    rs2_data = 32'd7;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    expect_out("hold0", 32'd5, 32'd7, ALU_ADD, 5'd3, 1'b1, 1'b0, 1'b0);
    in_instr = 32'h402081B3;
    in_pc    = 32'h404;
    rs1_data = 32'd9;
    rs2_data = 32'd1;
    chk("hold.in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("hold%0d.ctrl", i + 1), 32'(out_alu_ctrl), 32'(ALU_ADD));
      chk($sformatf("hold%0d.a", i + 1), out_operand_a, 32'd5);
      chk($sformatf("hold%0d.pc", i + 1), out_pc, 32'h400);
      chk($sformatf("hold%0d.in_ready", i + 1), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("rel.in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    expect_out("rel", 32'd9, 32'd1, ALU_SUB, 5'd3, 1'b1, 1'b0, 1'b0);
    chk("rel.pc", out_pc, 32'h404);
    @(posedge clk);
    #1;
    chk("drain.valid", 32'(out_valid), 32'd0);
`ifdef ALU_DECODE_PERF_EN
    chk("perf_issued", perf_issued, 32'd2);
    chk("perf_stall", perf_stall, 32'd3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
